// File: rtl/prime_detect5_pkg.sv
// Shared types and constants for the 5-bit prime detector.
// PRIME_MASK is a reference table for checking only; the design computes
// primality arithmetically and never indexes this constant.
package prime_det_pkg;

    localparam int OP_W = 5;

    typedef logic [OP_W-1:0] operand_t;

    // Bit n is set iff n is prime: 2,3,5,7,11,13,17,19,23,29,31.
    localparam logic [31:0] PRIME_MASK = 32'hA08A_28AC;

endpackage

// File: rtl/prime_detect5_if.sv
// Operand/flag bundle for the prime detector.
// The master drives the operand A and observes the flag B; the detector is the slave.
interface prime_detect5_if;
    import prime_det_pkg::*;

    operand_t A;
    logic     B;

    modport master (output A, input B);
    modport slave  (input A, output B);

endinterface

// File: rtl/prime_detect5_check.sv
// Combinational primality classifier for a 5-bit operand.
// Trial division by 2, 3 and 5 is enough, because every composite value
// up to 31 has a factor no larger than 5. Each remainder comes from a
// constant-divisor reduction: the operand bits are weighted by 2^i mod d,
// summed, and then folded back into range.
module prime_check5
    import prime_det_pkg::*;
(
    input  operand_t a,
    output logic     prime
);

    logic       mod2;
    logic [2:0] sum3;
    logic [1:0] mod3;
    logic [3:0] sum5;
    logic [3:0] mod5;

    // Remainders modulo 2, 3 and 5, built from weighted bit sums.
    always_comb begin
        mod2 = a[0];

        // Bit weights mod 3 are 1,2,1,2,1, so the sum is at most 7.
        sum3 = {2'b00, a[0]} + {1'b0, a[1], 1'b0} + {2'b00, a[2]}
             + {1'b0, a[3], 1'b0} + {2'b00, a[4]};
        case (sum3)
            3'd0, 3'd3, 3'd6: mod3 = 2'd0;
            3'd1, 3'd4, 3'd7: mod3 = 2'd1;
            default:          mod3 = 2'd2;
        endcase

        // Bit weights mod 5 are 1,2,4,3,1, so the sum is at most 11.
        sum5 = {3'b000, a[0]} + {2'b00, a[1], 1'b0} + {1'b0, a[2], 2'b00}
             + (a[3] ? 4'd3 : 4'd0) + {3'b000, a[4]};
        if (sum5 >= 4'd10) begin
            mod5 = sum5 - 4'd10;
        end else if (sum5 >= 4'd5) begin
            mod5 = sum5 - 4'd5;
        end else begin
            mod5 = sum5;
        end
    end

    // A value is prime when it is at least 2 and has no divisor among 2, 3 and 5 other than itself.
    always_comb begin
        prime = (a >= 5'd2)
             && ((a == 5'd2) || (mod2 != 1'b0))
             && ((a == 5'd3) || (mod3 != 2'd0))
             && ((a == 5'd5) || (mod5 != 4'd0));
    end

endmodule

// File: rtl/prime_detect5.sv
// Registered 5-bit prime detector: an input register, the prime_check5
// classifier, and an output flop that drives B.
// Build option PRIME_DET_SYNC_EN adds a second input flop, forming a 2-flop
// synchronizer for asynchronous switch inputs. That build has a latency of
// 3 cycles; the default build has a latency of 2 cycles.
module prime_detect5
    import prime_det_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    prime_detect5_if.slave  bus
);

    operand_t a_q;
    logic     prime_c;
    logic     b_q;

`ifdef PRIME_DET_SYNC_EN
    operand_t a_s1;

    // Two-flop synchronizer that brings the operand into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1 <= '0;
            a_q  <= '0;
        end else begin
            a_s1 <= bus.A;
            a_q  <= a_s1;
        end
    end
`else
    // Sample the operand on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
        end else begin
            a_q <= bus.A;
        end
    end
`endif

    prime_check5 u_check (
        .a     (a_q),
        .prime (prime_c)
    );

    // Register the classification so that B is a glitch-free flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= 1'b0;
        end else begin
            b_q <= prime_c;
        end
    end

    assign bus.B = b_q;

endmodule

// File: tb/tb_prime_detect5.sv
// Self-checking bench for prime_detect5. The build macro PRIME_DET_SYNC_EN
// selects the expected latency.
// The reference model records the operand sampled at each rising edge since
// the last reset. It predicts B by testing that operand for primality with
// plain trial division.
module tb_prime_detect5;
    import prime_det_pkg::*;

`ifdef PRIME_DET_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    operand_t histQ[$];

    prime_detect5_if bus ();

    prime_detect5 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Reference history: an asynchronous reset clears it, and each rising edge records A.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            histQ.delete();
        end else begin
            histQ.push_front(bus.A);
            if (histQ.size() > 8) begin
                void'(histQ.pop_back());
            end
        end
    end

    function automatic logic isPrime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d < n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Before a full latency has elapsed, the pipeline still holds reset zeros, and zero is not prime.
    function automatic logic expectB();
        if (histQ.size() < LAT) return 1'b0;
        return isPrime(int'(histQ[LAT-1]));
    endfunction

    task automatic checkBit(input string name, input logic got, input logic exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: B=%b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        bus.A = 5'd7;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("reset_hold", bus.B, 1'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkBit("reset_release", bus.B, (k == LAT) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] mask;
        mask = PRIME_MASK;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            bus.A = operand_t'(a);
            repeat (LAT + 1) @(negedge clk);
            checkBit($sformatf("sweep_model_A%0d", a), bus.B, expectB());
            checkBit($sformatf("sweep_mask_A%0d", a), bus.B, mask[a]);
        end
    endtask

    task automatic test_back_to_back();
        operand_t seq [6] = '{5'd2, 5'd4, 5'd3, 5'd9, 5'd29, 5'd27};
        logic     expv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 6 + LAT; c++) begin
            @(negedge clk);
            if (c >= LAT) begin
                checkBit($sformatf("b2b_%0d", c - LAT), bus.B, expv[c-LAT]);
            end
            bus.A = (c < 6) ? seq[c] : operand_t'($urandom_range(31, 0));
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            checkBit("random", bus.B, expectB());
            bus.A = operand_t'($urandom_range(31, 0));
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        bus.A = 5'd13;
        repeat (LAT + 1) @(negedge clk);
        checkBit("mid_before", bus.B, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("mid_async_clear", bus.B, 1'b0);
        @(negedge clk);
        checkBit("mid_held", bus.B, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            checkBit("mid_release", bus.B, (k == LAT) ? 1'b1 : 1'b0);
            checkBit("mid_release_model", bus.B, expectB());
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        bus.A = '0;
        test_reset();
        test_sweep();
        test_back_to_back();
        test_random();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
